marquee_feeder: RTL

MARQUEE_FEEDER -- requirements
Module: marquee_feeder

---
 rtl/marquee_pkg.sv | 24 ++
 rtl/marquee_tick.sv | 30 +++
 rtl/marquee_feeder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/marquee_pkg.sv
// ============================================================================
// marquee_pkg : shared FSM encoding, blank character and default parameters
//               for the marquee_feeder scrolling-text source.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package marquee_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SCROLL = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_BLANK    = 8'h20;
  localparam int         DEFAULT_DEPTH  = 64;
  localparam int         DEFAULT_TICK_W = 23;
  localparam int         DEFAULT_PAD    = 4;

endpackage

`default_nettype wire

// File: rtl/marquee_tick.sv
// ============================================================================
// marquee_tick : free-running TICK_W-bit prescaler; tick_o is high for the
//                single clock in which the counter reads all-ones.
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module marquee_tick #(
  parameter int TICK_W = 23
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  logic [TICK_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TICK_W'(1);
    end
  end

  assign tick_o = &cnt_q;

endmodule

`default_nettype wire

// File: rtl/marquee_feeder.sv
// ============================================================================
// marquee_feeder : buffers one ASCII message and replays it one character per
//                  prescaler tick, followed by PAD blanks. Defining
//                  MARQUEE_LOOP_EN makes the message repeat until reset.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module marquee_feeder
  import marquee_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int TICK_W = DEFAULT_TICK_W,
  parameter int PAD    = DEFAULT_PAD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  output logic [7:0] ascii_out,
  output logic       shift_en,
  output logic       busy
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              PW         = (PAD > 1) ? $clog2(PAD) : 1;
  localparam logic [AW:0]     C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [PW-1:0]   C_PAD_LAST = PW'(PAD - 1);

  state_t          state_q, state_d;
  logic [AW:0]     wr_cnt_q, wr_cnt_d;
  logic [AW:0]     msg_len_q, msg_len_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pad_cnt_q, pad_cnt_d;
  logic [7:0]      ascii_q, ascii_d;
  logic            shift_q, shift_d;
  logic [7:0]      mem_q [DEPTH];

  logic            w_tick;
  logic            w_wr_en;
  logic [AW:0]     w_wr_cnt_nxt;
  logic            w_msg_done;
  logic            w_last_char;
  logic            w_last_pad;

  marquee_tick #(.TICK_W(TICK_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (w_tick)
  );

  // Reaching DEPTH characters always ends loading, so LOAD is never full.
  assign wr_ready     = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy         = (state_q == ST_SCROLL) || (state_q == ST_FLUSH);
  assign w_wr_en      = wr_valid & wr_ready;
  assign w_wr_cnt_nxt = wr_cnt_q + (AW+1)'(1);
  assign w_msg_done   = w_wr_en & (wr_last | (w_wr_cnt_nxt == C_DEPTH));
  assign w_last_char  = (({1'b0, rd_ptr_q} + (AW+1)'(1)) == msg_len_q);
  assign w_last_pad   = (pad_cnt_q == C_PAD_LAST);
  assign ascii_out    = ascii_q;
  assign shift_en     = shift_q;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_cnt_q[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_cnt_q  <= '0;
      msg_len_q <= '0;
      rd_ptr_q  <= '0;
      pad_cnt_q <= '0;
      ascii_q   <= ASCII_BLANK;
      shift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      msg_len_q <= msg_len_d;
      rd_ptr_q  <= rd_ptr_d;
      pad_cnt_q <= pad_cnt_d;
      ascii_q   <= ascii_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (w_msg_done) begin
          state_d = ST_SCROLL;
        end else if (w_wr_en) begin
          state_d = ST_LOAD;
        end
      end
      ST_SCROLL: begin
        if (w_tick && w_last_char) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (w_tick && w_last_pad) begin
`ifdef MARQUEE_LOOP_EN
          state_d = ST_SCROLL;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers load only on a tick, so ascii_out holds between ticks.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    msg_len_d = msg_len_q;
    rd_ptr_d  = rd_ptr_q;
    pad_cnt_d = pad_cnt_q;
    ascii_d   = ascii_q;
    shift_d   = 1'b0;
    if (w_wr_en) begin
      wr_cnt_d = w_wr_cnt_nxt;
      if (w_msg_done) begin
        msg_len_d = w_wr_cnt_nxt;
      end
    end
    if (w_tick) begin
      case (state_q)
        ST_SCROLL: begin
          ascii_d   = mem_q[rd_ptr_q];
          shift_d   = 1'b1;
          rd_ptr_d  = w_last_char ? '0 : rd_ptr_q + AW'(1);
          pad_cnt_d = '0;
        end
        ST_FLUSH: begin
          ascii_d   = ASCII_BLANK;
          shift_d   = 1'b1;
          pad_cnt_d = w_last_pad ? '0 : pad_cnt_q + PW'(1);
`ifndef MARQUEE_LOOP_EN
          if (w_last_pad) begin
            wr_cnt_d = '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
